// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit write-only engine: byte -> two nibble strobes -> execution wait.
// Define LCD_INIT_EN to build the power-on initialisation sequence.
module lcd_byte_writer #(
  parameter int T_POWERUP = 60000,
  parameter int T_INIT1   = 16400,
  parameter int T_INIT2   = 400,
  parameter int T_CMD     = 160,
  parameter int T_CLEAR   = 6400
) (
  input  logic       clk_4Mhz,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic [3:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW
);
  localparam logic [15:0] W_CMD   = 16'(T_CMD - 1);
  localparam logic [15:0] W_CLEAR = 16'(T_CLEAR - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, EN_HI, HOLD, EXEC_WAIT
`ifdef LCD_INIT_EN
    , PWR_WAIT, INIT_NIB, INIT_WAIT
`endif
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] wait_q;
  logic [7:0]  byte_q;
  logic        lo_q;
  logic        en_ph;

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  function automatic logic [15:0] exec_len(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? W_CLEAR : W_CMD;
  endfunction

  assign LCD_RW = 1'b0;

`ifdef LCD_INIT_EN
  localparam logic [15:0] W_PWR   = 16'(T_POWERUP - 1);
  localparam logic [15:0] W_INIT1 = 16'(T_INIT1 - 1);
  localparam logic [15:0] W_INIT2 = 16'(T_INIT2 - 1);

  // step 0..3: single init nibbles; 4..7: full init bytes
  logic [2:0] step;
  logic       single_q;

  function automatic logic [15:0] init_wait(input logic [2:0] s);
    case (s)
      3'd0:    return W_INIT1;
      3'd1:    return W_INIT2;
      default: return W_CMD;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input logic [2:0] s);
    case (s)
      3'd4:    return 8'h28;
      3'd5:    return 8'h0C;
      3'd6:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  always_ff @(posedge clk_4Mhz) begin
    if (rst) begin
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 4'h0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
      byte_q    <= 8'h00;
      wait_q    <= W_CMD;
      lo_q      <= 1'b0;
      en_ph     <= 1'b0;
`ifdef LCD_INIT_EN
      state     <= PWR_WAIT;
      cnt       <= W_PWR;
      step      <= 3'd0;
      single_q  <= 1'b0;
`else
      state     <= IDLE;
      cnt       <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wr_valid && wr_ready) begin
            wr_ready <= 1'b0;
            byte_q   <= wr_data;
            wait_q   <= exec_len(wr_rs, wr_data);
            LCD_RS   <= wr_rs;
            LCD_DATA <= wr_data[7:4];
            lo_q     <= 1'b0;
            state    <= SETUP;
          end else begin
            wr_ready  <= 1'b1;
            init_done <= 1'b1;
          end
        end
        SETUP: begin
          LCD_EN <= 1'b1;
          en_ph  <= 1'b0;
          state  <= EN_HI;
        end
        EN_HI: begin
          if (!en_ph) begin
            en_ph <= 1'b1;
          end else begin
            LCD_EN <= 1'b0;
            state  <= HOLD;
          end
        end
        HOLD: begin
`ifdef LCD_INIT_EN
          if (single_q) begin
            single_q <= 1'b0;
            cnt      <= init_wait(step);
            state    <= INIT_WAIT;
          end else
`endif
          if (!lo_q) begin
            lo_q     <= 1'b1;
            LCD_DATA <= byte_q[3:0];
            state    <= SETUP;
          end else begin
            cnt   <= wait_q;
            state <= EXEC_WAIT;
          end
        end
        EXEC_WAIT: begin
          if (cnt != 16'h0) begin
            cnt <= cnt - 16'h1;
          end
`ifdef LCD_INIT_EN
          else if (!init_done && step != 3'd7) begin
            step     <= step + 3'd1;
            byte_q   <= init_byte(step + 3'd1);
            wait_q   <= exec_len(1'b0, init_byte(step + 3'd1));
            LCD_DATA <= init_byte(step + 3'd1) >> 4;
            lo_q     <= 1'b0;
            state    <= SETUP;
          end
`endif
          else begin
            wr_ready  <= 1'b1;
            init_done <= 1'b1;
            state     <= IDLE;
          end
        end
`ifdef LCD_INIT_EN
        PWR_WAIT: begin
          if (cnt != 16'h0) begin
            cnt <= cnt - 16'h1;
          end else begin
            LCD_DATA <= 4'h3;
            LCD_RS   <= 1'b0;
            single_q <= 1'b1;
            state    <= INIT_NIB;
          end
        end
        // setup cycle of a lone init nibble
        INIT_NIB: begin
          LCD_EN <= 1'b1;
          en_ph  <= 1'b0;
          state  <= EN_HI;
        end
        INIT_WAIT: begin
          if (cnt != 16'h0) begin
            cnt <= cnt - 16'h1;
          end else if (step == 3'd3) begin
            step     <= 3'd4;
            byte_q   <= init_byte(3'd4);
            wait_q   <= exec_len(1'b0, init_byte(3'd4));
            LCD_DATA <= init_byte(3'd4) >> 4;
            lo_q     <= 1'b0;
            state    <= SETUP;
          end else begin
            step     <= step + 3'd1;
            LCD_DATA <= (step == 3'd2) ? 4'h2 : 4'h3;
            single_q <= 1'b1;
            state    <= INIT_NIB;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_byte_writer.sv
// Scoreboard bench for lcd_byte_writer: expected nibbles queued at stimulus,
// EN pulses captured by a monitor and compared in each scenario task.
`timescale 1ns/1ps
module tb_lcd_byte_writer;
  localparam int T_POWERUP = 10, T_INIT1 = 5, T_INIT2 = 3, T_CMD = 4, T_CLEAR = 8;

  logic       clk_4Mhz = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, init_done, LCD_EN, LCD_RS, LCD_RW;
  logic [3:0] LCD_DATA;

  typedef struct packed {
    logic [4:0] bus;
    logic [3:0] width;
    logic       setup_ok;
    logic       hold_ok;
  } obs_t;

  int         checks = 0;
  int         errors = 0;
  int         en_pulses = 0;
  logic [4:0] exp_q[$];
  obs_t       obs_q[$];

  always #5 clk_4Mhz = ~clk_4Mhz;

  lcd_byte_writer #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2),
    .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk_4Mhz(clk_4Mhz), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_rs(wr_rs), .wr_data(wr_data), .init_done(init_done), .LCD_DATA(LCD_DATA),
    .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  // Pin monitor: one record per completed EN pulse (width, setup, hold, stability).
  logic       prev_en = 1'b0;
  logic [4:0] prev_bus = 5'h0;
  logic [4:0] cur = 5'h0;
  logic       stable = 1'b1;
  int         en_w = 0;
  always @(negedge clk_4Mhz) begin
    logic [4:0] bus;
    obs_t o;
    bus = {LCD_RS, LCD_DATA};
    if (rst) begin
      en_w = 0;
    end else if (LCD_EN && !prev_en) begin
      cur = bus; en_w = 1; stable = (prev_bus === bus); en_pulses++;
    end else if (LCD_EN) begin
      en_w++;
      if (bus !== cur) stable = 1'b0;
    end else if (prev_en) begin
      o.bus = cur;
      o.width = 4'((en_w > 15) ? 15 : en_w);
      o.setup_ok = stable;
      o.hold_ok = (bus === cur);
      obs_q.push_back(o);
    end
    prev_en = LCD_EN;
    prev_bus = bus;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst = 1'b1; wr_valid = 1'b0;
    repeat (3) @(posedge clk_4Mhz);
    @(negedge clk_4Mhz);
    checks++;
    if ({LCD_EN, LCD_RS, LCD_RW, LCD_DATA, wr_ready, init_done} !== 9'h0) begin
      errors++;
      $display("FAIL reset_values got en=%b rs=%b rw=%b data=%h ready=%b done=%b want all 0",
               LCD_EN, LCD_RS, LCD_RW, LCD_DATA, wr_ready, init_done);
    end
  endtask

`ifdef LCD_INIT_EN
  task automatic test_init;
    logic [3:0] nibs[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    int n, bad, base;
    obs_t o;
    logic [4:0] e;
    base = en_pulses; bad = 0;
    obs_q.delete();
    foreach (nibs[i]) exp_q.push_back({1'b0, nibs[i]});
    rst = 1'b0;
    for (n = 1; n <= T_POWERUP; n++) begin
      @(negedge clk_4Mhz);
      if (LCD_EN || wr_ready || init_done) bad++;
    end
    checks++;
    if (bad != 0 || en_pulses != base) begin
      errors++;
      $display("FAIL powerup_quiet got %0d busy cycles want 0", bad);
    end
    n = T_POWERUP;
    while (!init_done && n < 3000) begin @(negedge clk_4Mhz); n++; end
    // 10 powerup + 4 nibbles (4+5,4+3,4+4,4+4) + 4 bytes (8+4,8+4,8+8,8+4)
    checks++;
    if (n !== 94) begin
      errors++;
      $display("FAIL init_length got %0d cycles want 94", n);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL init_ready got %b want 1", wr_ready);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL init_pulse got extra rs/nib=%h want none", o.bus);
      end else begin
        e = exp_q.pop_front();
        if (o.bus !== e || o.width !== 4'd2 || !o.setup_ok || !o.hold_ok) begin
          errors++;
          $display("FAIL init_pulse got rs/nib=%h w=%0d setup=%b hold=%b want rs/nib=%h w=2",
                   o.bus, o.width, o.setup_ok, o.hold_ok, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL init_missing got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask
`else
  task automatic test_no_init;
    int base;
    base = en_pulses;
    obs_q.delete();
    rst = 1'b0;
    @(negedge clk_4Mhz);
    checks++;
    if (wr_ready !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL no_init_ready got ready=%b done=%b want 1 1", wr_ready, init_done);
    end
    repeat (20) @(negedge clk_4Mhz);
    checks++;
    if (en_pulses != base || LCD_EN !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_init_idle got pulses=%0d en=%b ready=%b want 0 0 1",
               en_pulses - base, LCD_EN, wr_ready);
    end
  endtask
`endif

  // Writes one byte and checks bus nibbles and the accept-to-next-accept gap.
  task automatic send(input logic rs, input logic [7:0] d, input int exp_gap);
    int n;
    obs_t o;
    logic [4:0] e;
    n = 0;
    while (!wr_ready && n < 500) begin @(negedge clk_4Mhz); n++; end
    checks++;
    if (!wr_ready) begin
      errors++; $display("FAIL send_ready got timeout want ready"); return;
    end
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    exp_q.push_back({rs, d[7:4]});
    exp_q.push_back({rs, d[3:0]});
    @(negedge clk_4Mhz);
    wr_valid = 1'b0; wr_data = 8'($urandom); wr_rs = 1'($urandom);
    n = 1;
    while (!wr_ready && n < 500) begin @(negedge clk_4Mhz); n++; end
    checks++;
    if (n !== exp_gap) begin
      errors++;
      $display("FAIL gap rs=%b byte=%h got %0d cycles want %0d", rs, d, n, exp_gap);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL pulse got extra rs/nib=%h want none", o.bus);
      end else begin
        e = exp_q.pop_front();
        if (o.bus !== e || o.width !== 4'd2 || !o.setup_ok || !o.hold_ok) begin
          errors++;
          $display("FAIL pulse got rs/nib=%h w=%0d setup=%b hold=%b want rs/nib=%h w=2",
                   o.bus, o.width, o.setup_ok, o.hold_ok, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pulse_missing got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_data;
    send(1'b1, 8'h41, 9 + T_CMD);
    send(1'b1, 8'hA5, 9 + T_CMD);
  endtask

  task automatic test_exec_len;
    send(1'b0, 8'h01, 9 + T_CLEAR);
    send(1'b0, 8'h02, 9 + T_CLEAR);
    send(1'b0, 8'h03, 9 + T_CLEAR);
    send(1'b0, 8'h04, 9 + T_CMD);
    send(1'b0, 8'h00, 9 + T_CMD);
    send(1'b1, 8'h01, 9 + T_CMD);
    send(1'b0, 8'h80, 9 + T_CMD);
  endtask

  // wr_valid held with garbage while busy; the next byte goes on the first ready cycle.
  task automatic test_back_to_back;
    int n, g1, g2;
    obs_t o;
    logic [4:0] e;
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
    exp_q.push_back(5'h15); exp_q.push_back(5'h15);
    n = 0;
    do begin
      @(negedge clk_4Mhz); n++;
      if (!wr_ready) begin
        wr_data = 8'($urandom); wr_rs = 1'($urandom);
      end else begin
        wr_rs = 1'b1; wr_data = 8'h3A;
        exp_q.push_back(5'h13); exp_q.push_back(5'h1A);
      end
    end while (!wr_ready && n < 500);
    g1 = n;
    n = 0;
    do begin
      @(negedge clk_4Mhz); n++;
      wr_valid = 1'b0;
    end while (!wr_ready && n < 500);
    g2 = n;
    checks++;
    if (g1 !== 9 + T_CMD || g2 !== 9 + T_CMD) begin
      errors++;
      $display("FAIL b2b_gap got %0d,%0d want %0d,%0d", g1, g2, 9 + T_CMD, 9 + T_CMD);
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_pulse got extra rs/nib=%h want none", o.bus);
      end else begin
        e = exp_q.pop_front();
        if (o.bus !== e || o.width !== 4'd2) begin
          errors++;
          $display("FAIL b2b_pulse got rs/nib=%h w=%0d want rs/nib=%h w=2", o.bus, o.width, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_missing got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reset lands in the first EN_HI cycle of the low nibble.
  task automatic test_reset_mid;
    obs_t o;
    wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
    @(negedge clk_4Mhz);
    wr_valid = 1'b0;
    repeat (5) @(negedge clk_4Mhz);
    checks++;
    if (LCD_EN !== 1'b1 || LCD_DATA !== 4'h1) begin
      errors++;
      $display("FAIL mid_strobe got en=%b data=%h want 1 1", LCD_EN, LCD_DATA);
    end
    #1 rst = 1'b1;
    @(negedge clk_4Mhz);
    checks++;
    if ({LCD_EN, LCD_RS, LCD_RW, LCD_DATA, wr_ready, init_done} !== 9'h0) begin
      errors++;
      $display("FAIL mid_reset got en=%b rs=%b rw=%b data=%h ready=%b done=%b want all 0",
               LCD_EN, LCD_RS, LCD_RW, LCD_DATA, wr_ready, init_done);
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL mid_pulses got %0d want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      checks++;
      if (o.bus !== 5'h14) begin
        errors++; $display("FAIL mid_hi_nibble got %h want 14", o.bus);
      end
    end
    obs_q.delete();
    @(posedge clk_4Mhz);
    @(negedge clk_4Mhz);
`ifdef LCD_INIT_EN
    test_init();
`else
    test_no_init();
`endif
  endtask

  initial begin
    test_reset();
`ifdef LCD_INIT_EN
    test_init();
`else
    test_no_init();
`endif
    test_data();
    test_exec_len();
    test_back_to_back();
    test_reset_mid();
    test_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_byte_writer.md
# lcd_byte_writer

Write-only HD44780 4-bit bus engine running on the divided `clk_4Mhz` domain. It accepts command/data bytes over a valid/ready handshake and splits each byte into two nibble strobes on `LCD_DATA`/`LCD_EN`/`LCD_RS`. It then holds off for the controller's execution time. An optional built-in power-on initialisation sequence is provided. It sits between the character/command source and the LCD pins, driven by the `clk_4Mhz` divider in the top level.

## Interface
- `T_POWERUP`, 60000: cycles waited after reset before the first init nibble (15 ms at 4 MHz).
- `T_INIT1`, 16400: wait after the first 0x3 init nibble (4.1 ms).
- `T_INIT2`, 400: wait after the second 0x3 init nibble (100 us).
- `T_CMD`, 160: post-byte execution wait for normal commands and data (40 us).
- `T_CLEAR`, 6400: post-byte wait for clear/home commands (1.6 ms).
- `clk_4Mhz`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `wr_valid`, in, 1: source presents a byte.
- `wr_ready`, out, 1: engine idle; a byte is accepted on `wr_valid && wr_ready`.
- `wr_rs`, in, 1: 0 selects a command, 1 selects data; captured at accept.
- `wr_data`, in, 8: byte; captured at accept.
- `init_done`, out, 1: init sequence complete; sticky until reset.
- `LCD_DATA`, out, 4: nibble bus.
- `LCD_EN`, out, 1: enable strobe.
- `LCD_RS`, out, 1: register select.
- `LCD_RW`, out, 1: tied 0 (write only).

## Operation
- States: PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SETUP, EN_HI, HOLD, EXEC_WAIT.
- Nibble strobe, 4 cycles:
  - SETUP (1 cycle): `LCD_RS`/`LCD_DATA` valid, EN=0.
  - EN_HI (2 cycles): EN=1.
  - HOLD (1 cycle): EN=0, data held.
- Byte transfer: high nibble `wr_data[7:4]`, then low nibble `wr_data[3:0]`, back-to-back (8 cycles), then EXEC_WAIT.
- EXEC_WAIT length:
  - `T_CLEAR` when `wr_rs=0` and `wr_data` is 0x01, 0x02 or 0x03.
  - `T_CMD` otherwise.
- `wr_ready` is 1 only in IDLE. It drops the cycle after accept and returns on the cycle after EXEC_WAIT expires. `wr_valid`/`wr_data` are ignored while not ready.
- Init sequence (with macro), all with RS=0:
  1. PWR_WAIT `T_POWERUP`.
  2. Nibble 0x3, wait `T_INIT1`.
  3. Nibble 0x3, wait `T_INIT2`.
  4. Nibble 0x3, wait `T_CMD`.
  5. Nibble 0x2, wait `T_CMD`.
  6. Bytes 0x28, 0x0C, 0x01 (wait `T_CLEAR`), 0x06.
  7. Then `init_done`=1 and IDLE.
- Wait counter: 16 bits, loaded with N−1 and decremented to 0, so a wait of N lasts exactly N cycles. Parameters must be in 1..65535.
- Reset values: `LCD_EN`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DATA`=0, `wr_ready`=0, `init_done`=0. State is PWR_WAIT (with macro) or IDLE (without).
- `rst` asserted mid-strobe or mid-wait: outputs take reset values on the next edge, EN is forced low, the captured byte is discarded, and the init sequence restarts.
- Between strobes `LCD_DATA` holds its last nibble; `LCD_RS` changes only in SETUP.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge k: SETUP at k+1, EN high k+2..k+3, HOLD k+4; low nibble SETUP k+5, EN high k+6..k+7, HOLD k+8.
- EXEC_WAIT runs k+9..k+8+W; `wr_ready`=1 at k+9+W.
- Byte throughput: one per 9+W cycles. Back-to-back accept is legal on the first ready cycle.
- EN high is 500 ns; RS/data setup before EN rise and hold after EN fall are each 250 ns.

## Configuration
- `LCD_INIT_EN` defined: the full init sequence runs after every reset; `wr_ready` stays 0 until it completes.
- `LCD_INIT_EN` undefined:
  - No init states are built.
  - `init_done` and `wr_ready` are 1 on the first cycle after reset release.
  - The source is responsible for initialising the controller.

## Test plan
- Init, `T_POWERUP`=10, `T_INIT1`=5, `T_INIT2`=3, `T_CMD`=4, `T_CLEAR`=8: EN pulses carry nibbles 3,3,3,2,2,8,0,C,0,1,0,6 with RS=0 each time; `init_done` rises the cycle after the 0x06 wait ends.
- Data write 0x41, RS=1: nibbles 4 then 1 with RS=1; each EN pulse is exactly 2 cycles; `wr_ready` returns 13 cycles after accept (`T_CMD`=4).
- Clear command 0x01, RS=0: wait uses `T_CLEAR`; `wr_ready` returns 17 cycles after accept. Command 0x80 returns after 13.
- `wr_valid` held high with changing `wr_data` while busy: only the accepted byte appears on the bus; the next byte is accepted on the first ready cycle.
- `rst` pulsed during the EN_HI of the low nibble: EN=0 on the next edge, all outputs at reset values, and the init sequence restarts from PWR_WAIT.
- Without `LCD_INIT_EN`: `wr_ready`=1 one cycle after reset release, with no EN activity before the first accept.
